mem_write_arbiter: RTL and testbench
====================================

MEM_WRITE_ARBITER -- requirements
Module: mem_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, memory address width.
REQ-002 SHALL have parameter FRAME_PIX, default 270400 (520x520), writes per requester per frame.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle pulse; begins a frame.
REQ-006 SHALL have port abort  in  1  cancels the frame and returns to idle.
REQ-007 SHALL have port mem_read_busy  in  1  shared SRAM is being read this cycle.
REQ-008 SHALL have port req_valid  in  4  write request per stage: [0] gauss, [1] grad, [2] supp, [3] hyst.
REQ-009 SHALL have port req_data  in  4x8  pixel per requester.
REQ-010 SHALL have port base_addr  in  4xADDR_W  region base per requester.
REQ-011 SHALL have port req_ready  out  4  one-hot-or-zero grant; handshake occurs when valid and ready are both high.
REQ-012 SHALL have port mem_write_enable  out  1  registered SRAM write strobe.
REQ-013 SHALL have port mem_addr  out  ADDR_W  registered write address.
REQ-014 SHALL have port mem_data  out  8  registered write data.
REQ-015 SHALL have port stage_done  out  4  per-requester frame-complete flags, sticky.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse when all four stages complete.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when stage_done is 4'b1111; DONE -> IDLE after one cycle; abort moves any state to IDLE on the next edge.
REQ-018 SHALL drive req_ready to zero in IDLE and DONE, and while mem_read_busy is high; reads always take priority over writes.
REQ-019 SHALL, in RUN, grant at most one requester per cycle, chosen among eligible requesters (valid and not stage_done) in round-robin order starting at (last_grant+1) mod 4.
REQ-020 SHALL update last_grant only on a handshake; a requester that drops valid loses its turn without stalling the others.
REQ-021 SHALL present req_ready combinationally from req_valid, the pointer, mem_read_busy and state; handshake to mem_write_enable latency is exactly 1 cycle.
REQ-022 SHALL, on handshake i, register mem_addr = (base_addr[i] + count[i]) mod 2^ADDR_W and mem_data = req_data[i], assert mem_write_enable for one cycle, and increment count[i].
REQ-023 SHALL set stage_done[i] and hold count[i] at 0 when a handshake occurs with count[i] == FRAME_PIX-1; no later handshake for i until the next start.
REQ-024 SHALL assert frame_done in the DONE cycle only.
REQ-025 SHALL clear all counts and stage_done on start accepted in IDLE; start in RUN or DONE is ignored.
REQ-026 SHALL, on abort, deassert mem_write_enable on the next edge and clear counts, stage_done and pointer; an abort coinciding with a handshake discards that write.
REQ-027 SHALL, when mem_read_busy rises while a requester holds valid, keep that requester's turn, granting it on the first free cycle if it is still valid.

Reset
REQ-028 SHALL, with rst high at an edge, enter IDLE, set last_grant=3, clear counts, stage_done, mem_write_enable, mem_addr, mem_data and frame_done; req_ready reads 0.

Configuration
REQ-029 SHALL, with MEM_WRITE_ARB_FIXED_PRI_EN defined, replace round-robin with fixed priority hyst > supp > grad > gauss (pointer unused); without it, round-robin per REQ-019.

Structure
REQ-030 SHALL take FRAME_PIX default, requester index enum (GAUSS, GRAD, SUPP, HYST) and FSM state typedef from shared package canny_mem_pkg.
REQ-031 SHALL place grant selection in sub-module rr_arbiter4, which contains the macro-selected policy; counters, FSM and output registers stay in mem_write_arbiter.

Verification
REQ-032 SHALL cover: reset, start, all four valid continuously -> grants 0,1,2,3,0,... one per cycle; mem_addr = base_i + n; write one cycle after each handshake.
REQ-033 SHALL cover: mem_read_busy high for 5 cycles with all valid -> req_ready=0 and no writes for 5 cycles; then grants resume at the held pointer.
REQ-034 SHALL cover: FRAME_PIX=4 override, only requester 2 valid -> 4 writes at base_2..base_2+3, stage_done=4'b0100, then ready stays 0 for requester 2.
REQ-035 SHALL cover: FRAME_PIX=4, all complete -> frame_done pulses exactly once, FSM returns to IDLE, and start is ignored during DONE.
REQ-036 SHALL cover: abort on a handshake cycle mid-frame -> no write the next cycle, counts cleared, and the next start writes again from base_i+0.
REQ-037 SHALL cover: MEM_WRITE_ARB_FIXED_PRI_EN defined, all valid -> requester 3 granted every cycle until stage_done[3], then 2, 1, 0.

Source files
------------

// File: rtl/canny_mem_pkg.sv
// Shared definitions for the Canny pipeline memory write path:
// frame size, requester indices and arbiter FSM states.
package canny_mem_pkg;

  localparam int FRAME_PIX_DEFAULT = 270400;  // 520 x 520
  localparam int NUM_REQ           = 4;

  typedef enum logic [1:0] {
    GAUSS = 2'd0,
    GRAD  = 2'd1,
    SUPP  = 2'd2,
    HYST  = 2'd3
  } req_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Requester handshake bundle plus the registered SRAM write port.
// The master modport is the requester/memory side; slave is the arbiter.
interface mem_write_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic [3:0]             req_valid;
  logic [3:0][7:0]        req_data;
  logic [3:0][ADDR_W-1:0] base_addr;
  logic [3:0]             req_ready;
  logic                   mem_write_enable;
  logic [ADDR_W-1:0]      mem_addr;
  logic [7:0]             mem_data;

  modport master (
    output req_valid, req_data, base_addr,
    input  req_ready, mem_write_enable, mem_addr, mem_data
  );

  modport slave (
    input  req_valid, req_data, base_addr,
    output req_ready, mem_write_enable, mem_addr, mem_data
  );
endinterface

// File: rtl/mem_write_arbiter_rr_arbiter4.sv
// Four-way grant selection. Round-robin from (last_grant+1) by default;
// defining MEM_WRITE_ARB_FIXED_PRI_EN selects fixed priority hyst > supp > grad > gauss.
module rr_arbiter4
  import canny_mem_pkg::*;
(
  input  logic       enable,
  input  logic [3:0] eligible,
  input  logic [1:0] last_grant,
  output logic [3:0] grant
);

`ifdef MEM_WRITE_ARB_FIXED_PRI_EN
  logic unused_ptr;
  assign unused_ptr = ^last_grant;

  always_comb begin
    grant = '0;
    if (enable) begin
      if (eligible[HYST])       grant[HYST]  = 1'b1;
      else if (eligible[SUPP])  grant[SUPP]  = 1'b1;
      else if (eligible[GRAD])  grant[GRAD]  = 1'b1;
      else if (eligible[GAUSS]) grant[GAUSS] = 1'b1;
    end
  end
`else
  always_comb begin
    logic [1:0] idx;
    grant = '0;
    idx   = '0;
    if (enable) begin
      for (int unsigned k = 1; k <= 4; k++) begin
        idx = last_grant + 2'(k);
        if (eligible[idx] && grant == '0) grant[idx] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates four pipeline stages onto one SRAM write port, reads taking priority.
// Grant policy lives in rr_arbiter4 (see MEM_WRITE_ARB_FIXED_PRI_EN there).
module mem_write_arbiter
  import canny_mem_pkg::*;
#(
  parameter int ADDR_W    = 19,
  parameter int FRAME_PIX = FRAME_PIX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                mem_read_busy,
  mem_write_arbiter_if.slave  bus,
  output logic [3:0]          stage_done,
  output logic                frame_done
);

  localparam int CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIX - 1);

  arb_state_e             state, state_next;
  logic [1:0]             last_grant;
  logic [3:0][CNT_W-1:0]  count;
  logic [3:0]             grant;
  logic                   run_en;
  logic                   hs;
  logic [1:0]             hs_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (stage_done == 4'b1111) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_comb begin
    run_en     = (state == ST_RUN) && !mem_read_busy;
    frame_done = (state == ST_DONE);
  end

  rr_arbiter4 u_arb (
    .enable     (run_en),
    .eligible   (bus.req_valid & ~stage_done),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign bus.req_ready = grant;

  always_comb begin
    hs     = |(grant & bus.req_valid);
    hs_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant[i]) hs_idx = 2'(i);
    end
  end

  // Abort wins over a coincident handshake: the requester saw ready, but the write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant           <= 2'd3;
      count                <= '0;
      stage_done           <= '0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_addr         <= '0;
      bus.mem_data         <= '0;
    end else begin
      bus.mem_write_enable <= 1'b0;
      if (abort) begin
        count      <= '0;
        stage_done <= '0;
        last_grant <= 2'd3;
      end else begin
        if (state == ST_IDLE && start) begin
          count      <= '0;
          stage_done <= '0;
        end
        if (hs) begin
          bus.mem_write_enable <= 1'b1;
          bus.mem_addr         <= bus.base_addr[hs_idx] + ADDR_W'(count[hs_idx]);
          bus.mem_data         <= bus.req_data[hs_idx];
          last_grant           <= hs_idx;
          if (count[hs_idx] == LAST_CNT) begin
            count[hs_idx]      <= '0;
            stage_done[hs_idx] <= 1'b1;
          end else begin
            count[hs_idx] <= count[hs_idx] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter with FRAME_PIX=4; honours MEM_WRITE_ARB_FIXED_PRI_EN.
module tb_mem_write_arbiter;

  localparam int ADDR_W = 19;
  localparam int FP     = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst, start, abort, busy;
  logic [3:0] stage_done;
  logic       frame_done;

  mem_write_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_write_arbiter #(.ADDR_W(ADDR_W), .FRAME_PIX(FP)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .mem_read_busy (busy),
    .bus           (bus),
    .stage_done    (stage_done),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  wr_t               exp_q[$];
  int                obs_log[$];
  int                fd_pulses = 0;
  int                m_state   = 0;
  logic [1:0]        m_ptr     = 2'd3;
  int                m_cnt[4];
  logic [3:0]        m_done    = '0;
  logic [ADDR_W-1:0] base[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] model_ready(input logic [3:0] valid);
    logic [3:0] elig;
    logic [3:0] g;
    logic [1:0] idx;
    g = '0;
    if (m_state != 1 || busy) return '0;
    elig = valid & ~m_done;
`ifdef MEM_WRITE_ARB_FIXED_PRI_EN
    for (int i = 3; i >= 0; i--) if (elig[i] && g == '0) g[i] = 1'b1;
`else
    for (int k = 1; k <= 4; k++) begin
      idx = m_ptr + 2'(k);
      if (elig[idx] && g == '0) g[idx] = 1'b1;
    end
`endif
    return g;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 4; i++) bus.req_data[i] = 8'($urandom);
  endtask

  // One clock: entered at negedge with inputs driven, leaves at the next negedge.
  task automatic cycle();
    logic [3:0] er;
    logic       hs, wr;
    int         gi, oi, nstate;
    wr_t        w;
    #1;
    er = model_ready(bus.req_valid);
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    hs = |(er & bus.req_valid);
    wr = hs && !abort && !rst;
    gi = 0;
    for (int i = 0; i < 4; i++) if (er[i]) gi = i;
    oi = -1;
    for (int i = 0; i < 4; i++) if (bus.req_ready[i] === 1'b1 && bus.req_valid[i]) oi = i;
    if (oi >= 0 && !abort && !rst) obs_log.push_back(oi);
    if (wr) begin
      w.addr = base[gi] + ADDR_W'(m_cnt[gi]);
      w.data = bus.req_data[gi];
      exp_q.push_back(w);
    end
    nstate = m_state;
    case (m_state)
      0: if (start) nstate = 1;
      1: if (m_done == 4'hF) nstate = 2;
      default: nstate = 0;
    endcase
    if (rst || abort) begin
      nstate = 0;
      m_ptr  = 2'd3;
      m_done = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (m_state == 0 && start) begin
        m_done = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end
      if (hs) begin
        m_ptr = 2'(gi);
        if (m_cnt[gi] == FP - 1) begin
          m_cnt[gi]  = 0;
          m_done[gi] = 1'b1;
        end else begin
          m_cnt[gi]++;
        end
      end
    end
    m_state = nstate;
    @(posedge clk);
    #1;
    chk("mem_write_enable", 32'(bus.mem_write_enable), 32'(wr));
    if (wr) begin
      w = exp_q.pop_front();
      chk("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
      chk("mem_data", 32'(bus.mem_data), 32'(w.data));
    end
    chk("stage_done", 32'(stage_done), 32'(m_done));
    chk("frame_done", 32'(frame_done), 32'(m_state == 2));
    if (frame_done === 1'b1) fd_pulses++;
    @(negedge clk);
  endtask

  initial begin
    int busy_cycles;
    int n;
    int expg;
    base[0] = 19'h01000;
    base[1] = 19'h22000;
    base[2] = 19'h44000;
    base[3] = 19'h7FFFE;  // wraps past 2^ADDR_W on the third write
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]          = 0;
      bus.base_addr[i]  = base[i];
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0; busy = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    cycle();
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'(0));
    chk("reset_mem_data", 32'(bus.mem_data), 32'(0));
    rst = 1'b0;

    // Full frame with all requesters valid, a 5-cycle read burst after six grants,
    // and a start pulse during DONE that must be ignored.
    bus.req_valid = 4'hF;
    rand_data();
    start = 1'b1;
    cycle();
    start = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (m_state != 0 && n < 60) begin
      rand_data();
      if (obs_log.size() == 6 && busy_cycles < 5) begin
        busy = 1'b1;
        busy_cycles++;
      end else begin
        busy = 1'b0;
      end
      start = (m_state == 2);
      cycle();
      n++;
    end
    start = 1'b0;
    busy  = 1'b0;
    chk("frame_done_pulses", 32'(fd_pulses), 32'(1));
    chk("grant_count", 32'(obs_log.size()), 32'(16));
    for (int i = 0; i < 16 && i < obs_log.size(); i++) begin
`ifdef MEM_WRITE_ARB_FIXED_PRI_EN
      expg = 3 - i / 4;
`else
      expg = i % 4;
`endif
      chk("grant_order", 32'(obs_log[i]), 32'(expg));
    end
    repeat (3) cycle();
    chk("idle_keeps_done", 32'(stage_done), 32'(4'hF));

    // Only SUPP valid: four writes then ready stays low for it
    obs_log.delete();
    bus.req_valid = 4'b0100;
    rand_data();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (8) begin
      rand_data();
      cycle();
    end
    chk("supp_writes", 32'(obs_log.size()), 32'(4));
    chk("supp_stage_done", 32'(stage_done), 32'(4'b0100));

    // Abort coinciding with a handshake, then restart from base+0
    bus.req_valid = 4'b0011;
    repeat (2) begin
      rand_data();
      cycle();
    end
    abort = 1'b1;
    rand_data();
    cycle();
    abort = 1'b0;
    cycle();
    bus.req_valid = 4'b0001;
    start = 1'b1;
    cycle();
    start = 1'b0;
    rand_data();
    cycle();
    chk("restart_addr", 32'(bus.mem_addr), 32'(base[0]));

    // Mixed traffic: random valid, read bursts, occasional starts and aborts
    for (int c = 0; c < 80; c++) begin
      rand_data();
      bus.req_valid = 4'($urandom_range(0, 15));
      busy  = ($urandom_range(0, 3) == 0);
      start = (m_state == 0) && ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 39) == 0);
      cycle();
    end
    start = 1'b0;
    abort = 1'b0;
    busy  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
